// File: rtl/mapper_mem_arbiter.sv
// mapper_mem_arbiter
//   Serialises mapper-translated PRG (CPU) and CHR (PPU) accesses onto one
//   shared memory port. Each side has a one-entry request latch. Grants are
//   round-robin when both sides are pending. Read data is returned in a
//   register, and a watchdog aborts an access when the memory never acks.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   prg_req/we/addr/wdata     PRG request strobe and access fields
//   prg_rdata, prg_done       PRG read data (held) and 1-cycle completion pulse
//   chr_*                     same as prg_*, for the CHR side
//   mem_req/we/addr/wdata     memory request, held until ack or timeout
//   mem_ack, mem_rdata        memory completion strobe, read data (same cycle)
//   overrun                   sticky: request dropped because its side was busy
//   timeout_err               sticky: watchdog expired on some access
module mapper_mem_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prg_req,
  input  logic              prg_we,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic [DATA_W-1:0] prg_wdata,
  output logic [DATA_W-1:0] prg_rdata,
  output logic              prg_done,
  input  logic              chr_req,
  input  logic              chr_we,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic [DATA_W-1:0] chr_wdata,
  output logic [DATA_W-1:0] chr_rdata,
  output logic              chr_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Expiry is detected one count early so mem_req stays high exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic {SIDE_PRG, SIDE_CHR} side_e;

  state_e            state_q, state_d;
  side_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic              prg_pend_q, prg_pend_d;
  logic              prg_we_l_q, prg_we_l_d;
  logic [ADDR_W-1:0] prg_addr_l_q, prg_addr_l_d;
  logic [DATA_W-1:0] prg_wdata_l_q, prg_wdata_l_d;
  logic              chr_pend_q, chr_pend_d;
  logic              chr_we_l_q, chr_we_l_d;
  logic [ADDR_W-1:0] chr_addr_l_q, chr_addr_l_d;
  logic [DATA_W-1:0] chr_wdata_l_q, chr_wdata_l_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] prg_rdata_q, prg_rdata_d;
  logic              prg_done_q, prg_done_d;
  logic [DATA_W-1:0] chr_rdata_q, chr_rdata_d;
  logic              chr_done_q, chr_done_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic              expire;
  logic              prg_clr, chr_clr;
  side_e             pick;

  assign expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wd_cnt_d      = wd_cnt_q;
    prg_pend_d    = prg_pend_q;
    prg_we_l_d    = prg_we_l_q;
    prg_addr_l_d  = prg_addr_l_q;
    prg_wdata_l_d = prg_wdata_l_q;
    chr_pend_d    = chr_pend_q;
    chr_we_l_d    = chr_we_l_q;
    chr_addr_l_d  = chr_addr_l_q;
    chr_wdata_l_d = chr_wdata_l_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    prg_rdata_d   = prg_rdata_q;
    chr_rdata_d   = chr_rdata_q;
    prg_done_d    = 1'b0;
    chr_done_d    = 1'b0;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    prg_clr       = 1'b0;
    chr_clr       = 1'b0;
    pick          = SIDE_PRG;

    unique case (state_q)
      S_IDLE: begin
        wd_cnt_d = '0;
        if (prg_pend_q || chr_pend_q) begin
          if (prg_pend_q && chr_pend_q) begin
            pick = (last_grant_q == SIDE_PRG) ? SIDE_CHR : SIDE_PRG;
          end else begin
            pick = prg_pend_q ? SIDE_PRG : SIDE_CHR;
          end
          state_d      = S_BUSY;
          last_grant_d = pick;
          mem_req_d    = 1'b1;
          if (pick == SIDE_PRG) begin
            mem_we_d    = prg_we_l_q;
            mem_addr_d  = prg_addr_l_q;
            mem_wdata_d = prg_wdata_l_q;
          end else begin
            mem_we_d    = chr_we_l_q;
            mem_addr_d  = chr_addr_l_q;
            mem_wdata_d = chr_wdata_l_q;
          end
        end
      end
      S_BUSY: begin
        // last_grant_q names the side owning the in-flight access.
        if (mem_ack || expire) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          wd_cnt_d  = '0;
          if (!mem_ack) timeout_d = 1'b1;
          if (last_grant_q == SIDE_PRG) begin
            prg_done_d = 1'b1;
            prg_clr    = 1'b1;
            if (!mem_we_q) prg_rdata_d = mem_ack ? mem_rdata : '1;
          end else begin
            chr_done_d = 1'b1;
            chr_clr    = 1'b1;
            if (!mem_we_q) chr_rdata_d = mem_ack ? mem_rdata : '1;
          end
        end else if (TIMEOUT != 0) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request landing on the completing edge of its own side is accepted.
    if (prg_req && (!prg_pend_q || prg_clr)) begin
      prg_pend_d    = 1'b1;
      prg_we_l_d    = prg_we;
      prg_addr_l_d  = prg_addr;
      prg_wdata_l_d = prg_wdata;
    end else if (prg_req) begin
      overrun_d = 1'b1;
    end else if (prg_clr) begin
      prg_pend_d = 1'b0;
    end

    if (chr_req && (!chr_pend_q || chr_clr)) begin
      chr_pend_d    = 1'b1;
      chr_we_l_d    = chr_we;
      chr_addr_l_d  = chr_addr;
      chr_wdata_l_d = chr_wdata;
    end else if (chr_req) begin
      overrun_d = 1'b1;
    end else if (chr_clr) begin
      chr_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= SIDE_CHR;
      wd_cnt_q      <= '0;
      prg_pend_q    <= 1'b0;
      prg_we_l_q    <= 1'b0;
      prg_addr_l_q  <= '0;
      prg_wdata_l_q <= '0;
      chr_pend_q    <= 1'b0;
      chr_we_l_q    <= 1'b0;
      chr_addr_l_q  <= '0;
      chr_wdata_l_q <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      prg_rdata_q   <= '0;
      prg_done_q    <= 1'b0;
      chr_rdata_q   <= '0;
      chr_done_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wd_cnt_q      <= wd_cnt_d;
      prg_pend_q    <= prg_pend_d;
      prg_we_l_q    <= prg_we_l_d;
      prg_addr_l_q  <= prg_addr_l_d;
      prg_wdata_l_q <= prg_wdata_l_d;
      chr_pend_q    <= chr_pend_d;
      chr_we_l_q    <= chr_we_l_d;
      chr_addr_l_q  <= chr_addr_l_d;
      chr_wdata_l_q <= chr_wdata_l_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      prg_rdata_q   <= prg_rdata_d;
      prg_done_q    <= prg_done_d;
      chr_rdata_q   <= chr_rdata_d;
      chr_done_q    <= chr_done_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign prg_rdata   = prg_rdata_q;
  assign prg_done    = prg_done_q;
  assign chr_rdata   = chr_rdata_q;
  assign chr_done    = chr_done_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
